// File: rtl/ntt_out_streamer.sv
// ntt_out_streamer
// Reads out all N = 16*2^ADDR_W coefficients of the NTT result memory, which
// is spread across 16 banks, and presents them as a valid/ready stream.
// Each coefficient index e maps to bank e[3:0] at address e[IDX_W-1:4].
// Banks have one cycle of read latency, so the mux select follows the
// read by one cycle. Returned words go into a 2-entry output buffer.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, bit_rev    readout request and order (bit_rev sampled with start)
//   bank_re/bank_addr shared read enable and address to all 16 banks
//   sel_out           16:1 output mux select, valid in the bank data cycle
//   Q_out             mux output (bank read data)
//   out_data/out_valid/out_ready/out_last  output stream
//   busy, done        run status and one-cycle completion pulse
module ntt_out_streamer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              bit_rev,
  output logic              bank_re,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [3:0]        sel_out,
  input  logic [DATA_W-1:0] Q_out,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = ADDR_W + 4;
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'((1 << IDX_W) - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_k;
  logic                r_bitrev;
  logic                r_inflight;
  logic                r_inflight_last;
  logic [3:0]          r_sel;
  logic [1:0]          r_cnt;
  logic [DATA_W-1:0]   r_data0;
  logic [DATA_W-1:0]   r_data1;
  logic                r_last0;
  logic                r_last1;

  logic [IDX_W-1:0]    w_e;
  logic                w_pop;
  logic                w_credit;
  logic                w_issue;
  logic                w_last_issue;

  function automatic logic [IDX_W-1:0] bit_reverse(input logic [IDX_W-1:0] v);
    logic [IDX_W-1:0] r;
    for (int i = 0; i < IDX_W; i++) begin
      r[i] = v[IDX_W-1-i];
    end
    return r;
  endfunction

  assign w_e   = r_bitrev ? bit_reverse(r_k[IDX_W-1:0]) : r_k[IDX_W-1:0];
  assign w_pop = (r_cnt != 2'd0) & out_ready;
  // Buffered + in-flight words, less the one leaving this cycle, must leave
  // room for one more so the 2-entry buffer can never overflow.
  assign w_credit     = (({1'b0, r_cnt} + {2'b00, r_inflight}) - {2'b00, w_pop}) < 3'd2;
  assign w_issue      = (r_state == S_RUN) & w_credit;
  assign w_last_issue = w_issue & (r_k == LAST_K);

  assign bank_re   = w_issue;
  assign bank_addr = w_issue ? w_e[IDX_W-1:4] : {ADDR_W{1'b0}};
  assign sel_out   = r_sel;
  assign out_data  = r_data0;
  assign out_valid = (r_cnt != 2'd0);
  // The head flag may hold a stale value once the buffer empties.
  assign out_last  = r_last0 & (r_cnt != 2'd0);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_RUN;
        else       w_next_state = S_IDLE;
      end
      S_RUN: begin
        if (w_last_issue) w_next_state = S_DRAIN;
        else              w_next_state = S_RUN;
      end
      S_DRAIN: begin
        if (w_pop & r_last0 & ~r_inflight) w_next_state = S_DONE;
        else                               w_next_state = S_DRAIN;
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Beat counter, order latch, in-flight tracking and mux select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k             <= {CNT_W{1'b0}};
      r_bitrev        <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_sel           <= 4'd0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_k      <= {CNT_W{1'b0}};
        r_bitrev <= bit_rev;
      end else if (w_issue) begin
        r_k <= r_k + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      r_inflight      <= w_issue;
      r_inflight_last <= w_last_issue;
      if (w_issue) begin
        r_sel <= w_e[3:0];
      end
    end
  end

  // 2-entry output buffer: entry 0 is the head driving the stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 2'd0;
      r_data0 <= {DATA_W{1'b0}};
      r_data1 <= {DATA_W{1'b0}};
      r_last0 <= 1'b0;
      r_last1 <= 1'b0;
    end else begin
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_data0 <= Q_out;
            r_last0 <= r_inflight_last;
          end else begin
            r_data1 <= Q_out;
            r_last1 <= r_inflight_last;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          if (r_cnt == 2'd2) begin
            r_data0 <= r_data1;
            r_last0 <= r_last1;
          end
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_data0 <= Q_out;
            r_last0 <= r_inflight_last;
          end else begin
            r_data0 <= r_data1;
            r_last0 <= r_last1;
            r_data1 <= Q_out;
            r_last1 <= r_inflight_last;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

endmodule
